// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core <-> data-memory request/response bundle
interface dmem_responder_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) ();
   logic              RD;
   logic              WR;
   logic [ADDR_W-1:0] Address;
   logic [2:0]        Funct3;
   logic [DATA_W-1:0] WRData;
   logic [DATA_W-1:0] RDData;
   logic              ready;
   logic              err;

   modport master (
      output RD, WR, Address, Funct3, WRData,
      input  RDData, ready, err
   );

   modport slave (
      input  RD, WR, Address, Funct3, WRData,
      output RDData, ready, err
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states, sizing and error detection
module dmem_responder #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int LAT    = 2
) (
   input logic              clk,
   input logic              rst,
   dmem_responder_if.slave  bus
);
   localparam int         WORDS  = 2 ** (ADDR_W - 2);
   localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_rd;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_f3;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_ready;
   logic              r_err;
   logic [DATA_W-1:0] r_mem [WORDS];

   logic [ADDR_W-3:0] w_idx;
   logic [1:0]        w_lane;
   logic [DATA_W-1:0] w_word;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_ld_data;
   logic              w_legal_ld;
   logic              w_legal_st;
   logic              w_misalign;
   logic              w_err;
   logic              w_finish;
   logic              w_do_store;

   assign w_idx  = r_addr[ADDR_W-1:2];
   assign w_lane = r_addr[1:0];
   assign w_word = r_mem[w_idx];
   assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_byte = w_word[7:0];
      case (w_lane)
         2'd1:    w_byte = w_word[15:8];
         2'd2:    w_byte = w_word[23:16];
         2'd3:    w_byte = w_word[31:24];
         default: w_byte = w_word[7:0];
      endcase
   end

   always_comb begin
      w_ld_data = w_word;
      case (r_f3)
         3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
         3'b100:  w_ld_data = {24'd0, w_byte};
         3'b101:  w_ld_data = {16'd0, w_half};
         default: w_ld_data = w_word;
      endcase
   end

   always_comb begin
      w_legal_ld = 1'b0;
      w_legal_st = 1'b0;
      case (r_f3)
         3'b000, 3'b001, 3'b010: begin
            w_legal_ld = 1'b1;
            w_legal_st = 1'b1;
         end
         3'b100, 3'b101: w_legal_ld = 1'b1;
         default: begin
            w_legal_ld = 1'b0;
            w_legal_st = 1'b0;
         end
      endcase
   end

   // Size comes from funct3[1:0] for both signed and unsigned loads.
   assign w_misalign = ((r_f3[1:0] == 2'b01) && r_addr[0]) ||
                       ((r_f3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
   assign w_err      = (r_rd && r_wr) || (r_rd && !w_legal_ld) ||
                       (r_wr && !w_legal_st) || w_misalign;
   assign w_finish   = (r_state == WAIT) && (r_cnt == 4'd0);
   assign w_do_store = w_finish && r_wr && !w_err;

   // No reset on the array; an async reset parks the FSM in IDLE, which blocks the write.
   always_ff @(posedge clk) begin
      if (w_do_store) begin
         case (r_f3[1:0])
            2'b00:   r_mem[w_idx][{w_lane, 3'b000} +: 8]     <= r_wdata[7:0];
            2'b01:   r_mem[w_idx][{w_lane[1], 4'b0000} +: 16] <= r_wdata[15:0];
            default: r_mem[w_idx]                            <= r_wdata;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_f3    <= 3'd0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               if (bus.RD || bus.WR) begin
                  r_rd    <= bus.RD;
                  r_wr    <= bus.WR;
                  r_addr  <= bus.Address;
                  r_f3    <= bus.Funct3;
                  r_wdata <= bus.WRData;
                  r_cnt   <= LAT_M1;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= RESP;
                  r_ready <= 1'b1;
                  r_err   <= w_err;
                  if (r_rd && !w_err)
                     r_rdata <= w_ld_data;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RESP: begin
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.RDData = r_rdata;
   assign bus.ready  = r_ready;
   assign bus.err    = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_responder_if #(.ADDR_W(9), .DATA_W(32)) bus  ();
   dmem_responder_if #(.ADDR_W(9), .DATA_W(32)) bus1 ();
   dmem_responder_if #(.ADDR_W(9), .DATA_W(32)) bus5 ();

   dmem_responder #(.ADDR_W(9), .DATA_W(32), .LAT(LAT)) dut    (.clk(clk), .rst(rst), .bus(bus));
   dmem_responder #(.ADDR_W(9), .DATA_W(32), .LAT(1))   u_lat1 (.clk(clk), .rst(rst), .bus(bus1));
   dmem_responder #(.ADDR_W(9), .DATA_W(32), .LAT(5))   u_lat5 (.clk(clk), .rst(rst), .bus(bus5));

   typedef struct {
      logic        rd;
      logic        wr;
      logic [8:0]  addr;
      logic [2:0]  f3;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [8:0] a,
                        input logic [2:0] f3, input logic [31:0] wd);
      bus.RD      = rd;
      bus.WR      = wr;
      bus.Address = a;
      bus.Funct3  = f3;
      bus.WRData  = wd;
   endtask

   task automatic wait_resp(input string name);
      int   k;
      exp_t e;
      k = 0;
      while (bus.ready !== 1'b1 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk_eq({name, " latency"}, 32'(k), 32'(LAT));
      if (bus.ready === 1'b1) begin
         chk_eq({name, " sb_depth"}, 32'(sb_q.size()), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_eq({name, " rddata"}, bus.RDData, e.rdata);
            chk_eq({name, " err"}, 32'(bus.err), 32'(e.err));
         end
      end else if (sb_q.size() > 0) begin
         void'(sb_q.pop_front());
      end
      @(posedge clk); #1;
      chk_eq({name, " ready_pulse"}, 32'(bus.ready), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      drive(v.rd, v.wr, v.addr, v.f3, v.wd);
      sb_q.push_back('{v.exp_rd, v.exp_err});
      @(posedge clk); #1;
      bus.RD = 1'b0;
      bus.WR = 1'b0;
      wait_resp(name);
   endtask

   initial begin
      int r1[$];
      int r5[$];
      int d1;
      int d5;

      drive(1'b0, 1'b0, 9'h000, 3'b010, 32'd0);
      {bus1.RD, bus1.WR, bus1.Address, bus1.Funct3, bus1.WRData} = {2'b00, 9'h000, 3'b010, 32'd0};
      {bus5.RD, bus5.WR, bus5.Address, bus5.Funct3, bus5.WRData} = {2'b00, 9'h000, 3'b010, 32'd0};
      rst = 1'b1;

      vecs.push_back('{0, 1, 9'h010, 3'b010, 32'hDEADBEEF, 32'h00000000, 0});
      vecs.push_back('{1, 0, 9'h010, 3'b010, 32'h0,        32'hDEADBEEF, 0});
      vecs.push_back('{0, 1, 9'h010, 3'b010, 32'h0,        32'hDEADBEEF, 0});
      vecs.push_back('{0, 1, 9'h013, 3'b000, 32'h00000080, 32'hDEADBEEF, 0});
      vecs.push_back('{1, 0, 9'h013, 3'b000, 32'h0,        32'hFFFFFF80, 0});
      vecs.push_back('{1, 0, 9'h013, 3'b100, 32'h0,        32'h00000080, 0});
      vecs.push_back('{1, 0, 9'h010, 3'b010, 32'h0,        32'h80000000, 0});
      vecs.push_back('{0, 1, 9'h020, 3'b010, 32'h0,        32'h80000000, 0});
      vecs.push_back('{0, 1, 9'h022, 3'b001, 32'h1234ABCD, 32'h80000000, 0});
      vecs.push_back('{1, 0, 9'h022, 3'b001, 32'h0,        32'hFFFFABCD, 0});
      vecs.push_back('{1, 0, 9'h022, 3'b101, 32'h0,        32'h0000ABCD, 0});
      vecs.push_back('{1, 0, 9'h020, 3'b010, 32'h0,        32'hABCD0000, 0});
      vecs.push_back('{1, 0, 9'h011, 3'b010, 32'h0,        32'hABCD0000, 1});
      vecs.push_back('{0, 1, 9'h021, 3'b001, 32'h00005555, 32'hABCD0000, 1});
      vecs.push_back('{1, 0, 9'h020, 3'b010, 32'h0,        32'hABCD0000, 0});
      vecs.push_back('{1, 1, 9'h020, 3'b010, 32'h0,        32'hABCD0000, 1});
      vecs.push_back('{1, 0, 9'h020, 3'b011, 32'h0,        32'hABCD0000, 1});
      vecs.push_back('{0, 1, 9'h020, 3'b100, 32'hFFFFFFFF, 32'hABCD0000, 1});
      vecs.push_back('{1, 0, 9'h020, 3'b010, 32'h0,        32'hABCD0000, 0});
      vecs.push_back('{1, 0, 9'h012, 3'b001, 32'h0,        32'hFFFF8000, 0});
      vecs.push_back('{1, 0, 9'h012, 3'b101, 32'h0,        32'h00008000, 0});
      vecs.push_back('{0, 1, 9'h030, 3'b010, 32'h11111111, 32'h00008000, 0});

      repeat (2) @(posedge clk);
      #1;
      chk_eq("reset rddata", bus.RDData, 32'd0);
      chk_eq("reset ready", 32'(bus.ready), 32'd0);
      chk_eq("reset err", 32'(bus.err), 32'd0);
      chk_eq("reset ready lat1", 32'(bus1.ready), 32'd0);
      chk_eq("reset ready lat5", 32'(bus5.ready), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Held load on the LAT=1 and LAT=5 builds: first ready at t0+LAT, then every LAT+2.
      bus1.RD = 1'b1;
      bus5.RD = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk); #1;
         if (bus1.ready === 1'b1) r1.push_back(cyc);
         if (bus5.ready === 1'b1) r5.push_back(cyc);
      end
      bus1.RD = 1'b0;
      bus5.RD = 1'b0;
      chk_eq("lat1 pulses", 32'(r1.size() >= 2), 32'd1);
      chk_eq("lat5 pulses", 32'(r5.size() >= 2), 32'd1);
      d1 = (r1.size() >= 2) ? r1[1] - r1[0] : -1;
      d5 = (r5.size() >= 2) ? r5[1] - r5[0] : -1;
      chk_eq("lat1 first", 32'((r1.size() > 0) ? r1[0] : -1), 32'd2);
      chk_eq("lat1 period", 32'(d1), 32'd3);
      chk_eq("lat5 first", 32'((r5.size() > 0) ? r5[0] : -1), 32'd6);
      chk_eq("lat5 period", 32'(d5), 32'd7);
      repeat (10) @(posedge clk);
      #1;

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Inputs changed during WAIT must not affect the captured request.
      drive(1'b1, 1'b0, 9'h010, 3'b010, 32'd0);
      sb_q.push_back('{32'h80000000, 1'b0});
      @(posedge clk); #1;
      bus.RD      = 1'b0;
      bus.Address = 9'h020;
      bus.Funct3  = 3'b011;
      wait_resp("wait_change");

      drive(1'b0, 1'b1, 9'h030, 3'b010, 32'h00000055);
      @(posedge clk); #1;
      bus.WR = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      for (int c = 0; c < 3; c++) begin
         chk_eq($sformatf("rst_mid rddata %0d", c), bus.RDData, 32'd0);
         chk_eq($sformatf("rst_mid ready %0d", c), 32'(bus.ready), 32'd0);
         chk_eq($sformatf("rst_mid err %0d", c), 32'(bus.err), 32'd0);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      chk_eq("post_rst ready", 32'(bus.ready), 32'd0);
      run_vec('{1, 0, 9'h030, 3'b010, 32'h0, 32'h11111111, 0}, "post_rst lw");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
